// File: rtl/sprite_pkg.sv
// Shared types and constants for the per-scanline sprite scheduler.
package sprite_pkg;

    localparam int unsigned SPRITE_SIZE = 32;
    localparam int unsigned SPRITE_BITS = 5;
    localparam int unsigned COORD_BITS  = 10;
    localparam int unsigned IDX_BITS    = 4;

    typedef struct packed {
        logic                  enable;
        logic [COORD_BITS-1:0] posx;
        logic [COORD_BITS-1:0] posy;
    } sprite_entry_t;

    typedef struct packed {
        logic                   valid;
        logic [IDX_BITS-1:0]    idx;
        logic [COORD_BITS-1:0]  posx;
        logic [SPRITE_BITS-1:0] row;
    } slot_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        READY
    } state_t;

    // Wrapping offset from a sprite edge lands inside the 32-pixel span.
    function automatic logic in_sprite(input logic [COORD_BITS-1:0] d);
        return d < COORD_BITS'(SPRITE_SIZE);
    endfunction

endpackage

// File: rtl/sprite_slot_hit.sv
// Per-slot horizontal hit test: column offset of pixelx inside one selected sprite.
module sprite_slot_hit
    import sprite_pkg::*;
(
    input  logic [COORD_BITS-1:0]  pixelx,
    input  slot_t                  slot,
    output logic                   hit_c,
    output logic [SPRITE_BITS-1:0] col_c
);

    logic [COORD_BITS-1:0] col_full;
    logic                  unused_slot;

    always_comb begin
        col_full = pixelx - slot.posx;
        hit_c    = slot.valid && in_sprite(col_full);
        col_c    = col_full[SPRITE_BITS-1:0];
    end

    assign unused_slot = ^{slot.idx, slot.row};

endmodule

// File: rtl/sprite_line_scheduler.sv
// Scans the sprite table during blanking for the next line, then arbitrates
// the committed slots per pixel to drive the sprite-ROM address.
module sprite_line_scheduler
    import sprite_pkg::*;
#(
    parameter int unsigned NUM_SPRITES = 8,
    parameter int unsigned SLOTS       = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cfg_we,
    input  logic [$clog2(NUM_SPRITES)-1:0] cfg_idx,
    input  logic                           cfg_enable,
    input  logic [COORD_BITS-1:0]          cfg_posx,
    input  logic [COORD_BITS-1:0]          cfg_posy,
    input  logic                           hsync_start,
    input  logic [COORD_BITS-1:0]          next_line,
    input  logic                           line_start,
    input  logic [COORD_BITS-1:0]          pixelx,
    input  logic [COORD_BITS-1:0]          pixely,
    input  logic                           video_on,
    output logic [COORD_BITS-1:0]          rom_addr,
    output logic [$clog2(NUM_SPRITES)-1:0] rom_sel,
    output logic                           hit,
    output logic                           overflow,
    output logic                           late,
    output logic                           busy
);

    localparam int unsigned IW = $clog2(NUM_SPRITES);
    localparam int unsigned CW = $clog2(SLOTS + 1);

    sprite_entry_t          tbl [NUM_SPRITES];
    state_t                 state, state_next;
    logic [IW-1:0]          scan_idx;
    logic [COORD_BITS-1:0]  scan_line;
    slot_t                  pend [SLOTS];
    logic [CW-1:0]          pend_cnt;
    logic                   overflow_pend;
    slot_t                  act [SLOTS];

    logic                   scan_restart, do_commit, do_abort, do_clear;
    sprite_entry_t          scan_entry;
    logic [COORD_BITS-1:0]  scan_row;
    logic                   scan_cand;

    logic [SLOTS-1:0]       slot_hit;
    logic [SPRITE_BITS-1:0] slot_col [SLOTS];
    logic                   any_hit;
    logic [COORD_BITS-1:0]  win_addr;
    logic [IW-1:0]          win_sel;
    logic                   unused_pixely;

    assign unused_pixely = ^pixely;

    // Sprite table
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) tbl[i] <= '0;
        end else if (cfg_we) begin
            tbl[cfg_idx] <= '{enable: cfg_enable, posx: cfg_posx, posy: cfg_posy};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state and line-boundary control; hsync_start always (re)starts a scan.
    always_comb begin
        state_next   = state;
        scan_restart = 1'b0;
        do_commit    = 1'b0;
        do_abort     = 1'b0;
        do_clear     = 1'b0;
        if (hsync_start) begin
            state_next   = SCAN;
            scan_restart = 1'b1;
        end else begin
            case (state)
                SCAN:    if (scan_idx == IW'(NUM_SPRITES - 1)) state_next = READY;
                READY:   if (line_start) state_next = IDLE;
                default: state_next = state;
            endcase
        end
        if (line_start) begin
            case (state)
                READY:   do_commit = 1'b1;
                SCAN:    do_abort  = 1'b1;
                default: do_clear  = 1'b1;
            endcase
        end
    end

    always_comb begin
        scan_entry = tbl[scan_idx];
        scan_row   = scan_line - scan_entry.posy;
        scan_cand  = scan_entry.enable && in_sprite(scan_row);
    end

    // Scan datapath: one table entry per cycle into the pending list.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_idx      <= '0;
            scan_line     <= '0;
            pend_cnt      <= '0;
            overflow_pend <= 1'b0;
            for (int s = 0; s < SLOTS; s++) pend[s] <= '0;
        end else if (scan_restart) begin
            scan_idx      <= '0;
            scan_line     <= next_line;
            pend_cnt      <= '0;
            overflow_pend <= 1'b0;
            for (int s = 0; s < SLOTS; s++) pend[s] <= '0;
        end else if (state == SCAN) begin
            scan_idx <= scan_idx + IW'(1);
            if (scan_cand) begin
                if (pend_cnt < CW'(SLOTS)) begin
                    for (int s = 0; s < SLOTS; s++) begin
                        if (pend_cnt == CW'(s)) begin
                            pend[s] <= '{valid: 1'b1,
                                         idx:   IDX_BITS'(scan_idx),
                                         posx:  scan_entry.posx,
                                         row:   scan_row[SPRITE_BITS-1:0]};
                        end
                    end
                    pend_cnt <= pend_cnt + CW'(1);
                end else begin
                    overflow_pend <= 1'b1;
                end
            end
        end
    end

    // Active list and line status, updated only on line_start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SLOTS; s++) act[s] <= '0;
            overflow <= 1'b0;
            late     <= 1'b0;
        end else if (do_commit) begin
            for (int s = 0; s < SLOTS; s++) act[s] <= pend[s];
            overflow <= overflow_pend;
            late     <= 1'b0;
        end else if (do_abort) begin
            for (int s = 0; s < SLOTS; s++) act[s] <= '0;
            overflow <= 1'b0;
            late     <= 1'b1;
        end else if (do_clear) begin
            for (int s = 0; s < SLOTS; s++) act[s] <= '0;
            overflow <= 1'b0;
            late     <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) busy <= 1'b0;
        else       busy <= (state_next == SCAN);
    end

    for (genvar g = 0; g < SLOTS; g++) begin : g_slot
        sprite_slot_hit u_hit (
            .pixelx (pixelx),
            .slot   (act[g]),
            .hit_c  (slot_hit[g]),
            .col_c  (slot_col[g])
        );
    end

    // Lowest slot wins, which is the lowest sprite index.
    always_comb begin
        any_hit  = 1'b0;
        win_addr = '0;
        win_sel  = '0;
        for (int s = 0; s < SLOTS; s++) begin
            if (slot_hit[s] && !any_hit) begin
                any_hit  = 1'b1;
                win_addr = {act[s].row, slot_col[s]};
                win_sel  = IW'(act[s].idx);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit      <= 1'b0;
            rom_addr <= '0;
            rom_sel  <= '0;
        end else begin
            hit      <= video_on && any_hit;
            rom_addr <= (video_on && any_hit) ? win_addr : '0;
            rom_sel  <= (video_on && any_hit) ? win_sel : '0;
        end
    end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Directed bench for sprite_line_scheduler with a line-level reference model.
module tb_sprite_line_scheduler;

    localparam int N  = 8;
    localparam int S  = 4;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_we, cfg_enable;
    logic [IW-1:0] cfg_idx;
    logic [9:0]    cfg_posx, cfg_posy;
    logic          hsync_start, line_start, video_on;
    logic [9:0]    next_line, pixelx, pixely;
    logic [9:0]    rom_addr;
    logic [IW-1:0] rom_sel;
    logic          hit, overflow, late, busy;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_on = 0;

    sprite_line_scheduler #(.NUM_SPRITES(N), .SLOTS(S)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_enable(cfg_enable), .cfg_posx(cfg_posx), .cfg_posy(cfg_posy),
        .hsync_start(hsync_start), .next_line(next_line), .line_start(line_start),
        .pixelx(pixelx), .pixely(pixely), .video_on(video_on),
        .rom_addr(rom_addr), .rom_sel(rom_sel), .hit(hit),
        .overflow(overflow), .late(late), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: table contents, pending scan, committed sprite list.
    bit m_en [N];
    int m_px [N];
    int m_py [N];
    int m_cyc = 0, m_hs_edge = 0, m_line = 0, m_act_n = 0;
    bit m_scan_valid = 0;
    int m_ai [S];
    int m_ax [S];
    int m_ar [S];
    int exp_hit = 0, exp_addr = 0, exp_sel = 0, exp_ovf = 0, exp_late = 0, exp_busy = 0;

    always @(posedge clk) begin
        int col, row, n;
        bit found, ov;
        m_cyc++;
        if (reset) begin
            for (int i = 0; i < N; i++) begin m_en[i] = 0; m_px[i] = 0; m_py[i] = 0; end
            m_scan_valid = 0; m_act_n = 0;
            exp_hit = 0; exp_addr = 0; exp_sel = 0; exp_ovf = 0; exp_late = 0; exp_busy = 0;
        end else begin
            exp_hit = 0; exp_addr = 0; exp_sel = 0; found = 0;
            if (video_on) begin
                for (int s = 0; s < m_act_n; s++) begin
                    col = (int'(pixelx) - m_ax[s]) & 1023;
                    if (!found && col < 32) begin
                        found = 1; exp_hit = 1;
                        exp_addr = m_ar[s] * 32 + col; exp_sel = m_ai[s];
                    end
                end
            end
            if (line_start) begin
                if (m_scan_valid && (m_cyc - m_hs_edge) > N) begin
                    n = 0; ov = 0;
                    for (int i = 0; i < N; i++) begin
                        row = (m_line - m_py[i]) & 1023;
                        if (m_en[i] && row < 32) begin
                            if (n < S) begin
                                m_ai[n] = i; m_ax[n] = m_px[i]; m_ar[n] = row; n++;
                            end else ov = 1;
                        end
                    end
                    m_act_n = n; exp_ovf = int'(ov); exp_late = 0; m_scan_valid = 0;
                end else if (m_scan_valid) begin
                    m_act_n = 0; exp_late = 1; exp_ovf = 0;
                end else begin
                    m_act_n = 0; exp_late = 0; exp_ovf = 0;
                end
            end
            if (hsync_start) begin
                m_scan_valid = 1; m_hs_edge = m_cyc; m_line = int'(next_line);
            end
            exp_busy = int'(m_scan_valid && (m_cyc - m_hs_edge) < N);
            if (cfg_we) begin
                m_en[cfg_idx] = cfg_enable; m_px[cfg_idx] = int'(cfg_posx); m_py[cfg_idx] = int'(cfg_posy);
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            check("hit",      int'(hit),      exp_hit);
            check("rom_addr", int'(rom_addr), exp_addr);
            check("rom_sel",  int'(rom_sel),  exp_sel);
            check("overflow", int'(overflow), exp_ovf);
            check("late",     int'(late),     exp_late);
            check("busy",     int'(busy),     exp_busy);
        end
    end

    task automatic write_entry(input int i, input bit en, input int x, input int y);
        cfg_we = 1; cfg_idx = IW'(i); cfg_enable = en; cfg_posx = 10'(x); cfg_posy = 10'(y);
        @(negedge clk);
        cfg_we = 0;
    endtask

    task automatic start_scan(input int line);
        hsync_start = 1; next_line = 10'(line);
        @(negedge clk);
        hsync_start = 0;
    endtask

    task automatic pulse_line_start();
        line_start = 1;
        @(negedge clk);
        line_start = 0;
    endtask

    task automatic full_line(input int line);
        start_scan(line);
        repeat (N + 1) @(negedge clk);
        pulse_line_start();
    endtask

    task automatic sweep(input int x0, input int x1);
        video_on = 1;
        for (int x = x0; x <= x1; x++) begin pixelx = 10'(x); @(negedge clk); end
        video_on = 0;
    endtask

    task automatic pixel(input int x);
        video_on = 1; pixelx = 10'(x);
        @(negedge clk);
    endtask

    initial begin
        reset = 1; cfg_we = 0; cfg_idx = '0; cfg_enable = 0; cfg_posx = '0; cfg_posy = '0;
        hsync_start = 0; next_line = '0; line_start = 0; pixelx = '0; pixely = '0; video_on = 0;
        repeat (3) @(negedge clk);
        check("rst_hit", int'(hit), 0);
        check("rst_addr", int'(rom_addr), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_late", int'(late), 0);
        reset = 0; chk_on = 1;

        // Single sprite: entry 2 at (100,50), line 60 -> row 10
        write_entry(2, 1, 100, 50);
        full_line(60);
        pixel(99);  check("s_x99_hit", int'(hit), 0);
        pixel(100); check("s_x100_hit", int'(hit), 1); check("s_x100_sel", int'(rom_sel), 2);
                    check("s_x100_addr", int'(rom_addr), 320);
        pixel(131); check("s_x131_addr", int'(rom_addr), 351);
        pixel(132); check("s_x132_hit", int'(hit), 0);
        sweep(90, 140);

        // Overlap priority: entries 1 and 3 at (200,0), line 5
        write_entry(2, 0, 0, 0);
        write_entry(1, 1, 200, 0);
        write_entry(3, 1, 200, 0);
        full_line(5);
        pixel(205); check("ov_sel", int'(rom_sel), 1); check("ov_addr", int'(rom_addr), 165);
                    check("ov_ovf", int'(overflow), 0);
        sweep(190, 240);

        // Overflow: six sprites on line 10, only 0..3 drawn
        for (int i = 0; i < 6; i++) write_entry(i, 1, i * 40, 5);
        full_line(10);
        check("of_flag", int'(overflow), 1);
        pixel(125); check("of_sel3", int'(rom_sel), 3);
        pixel(165); check("of_no4", int'(hit), 0);
        sweep(0, 250);
        for (int i = 1; i < 6; i++) write_entry(i, 0, i * 40, 5);
        full_line(10);
        check("of_clear", int'(overflow), 0);
        sweep(0, 40);

        // Late commit: line_start three cycles after hsync_start
        start_scan(10);
        repeat (2) @(negedge clk);
        pulse_line_start();
        check("late_flag", int'(late), 1);
        check("late_busy", int'(busy), 1);
        pixel(5); check("late_nohit", int'(hit), 0);
        video_on = 0;
        repeat (N) @(negedge clk);

        // Vertical wrap: posy 1020 on line 4 gives row 8
        write_entry(6, 1, 300, 1020);
        full_line(4);
        check("wrap_late", int'(late), 0);
        pixel(310); check("wrap_sel", int'(rom_sel), 6); check("wrap_addr", int'(rom_addr), 266);
        sweep(290, 340);

        // Restart mid-scan keeps busy for another full scan
        start_scan(4);
        repeat (2) @(negedge clk);
        start_scan(4);
        repeat (N - 1) @(negedge clk);
        check("rs_busy_hi", int'(busy), 1);
        @(negedge clk);
        check("rs_busy_lo", int'(busy), 0);
        pulse_line_start();
        pixel(310); check("rs_hit", int'(hit), 1);

        // Reset mid-line with a hit and a scan in flight
        hsync_start = 1; next_line = 10'd4; pixelx = 10'd310; video_on = 1;
        @(negedge clk);
        hsync_start = 0;
        check("pre_rst_hit", int'(hit), 1);
        check("pre_rst_busy", int'(busy), 1);
        #2 reset = 1;
        #1;
        check("ar_hit", int'(hit), 0);
        check("ar_addr", int'(rom_addr), 0);
        check("ar_busy", int'(busy), 0);
        check("ar_ovf", int'(overflow), 0);
        check("ar_late", int'(late), 0);
        repeat (2) @(negedge clk);
        reset = 0;
        video_on = 0;
        full_line(4);
        pixel(310); check("post_rst_tbl", int'(hit), 0);
        sweep(290, 340);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
